// File: rtl/io_bus_master_if.sv
// I/O port bundle between the control unit, the bus master and the peripherals.
// The master modport is the initiator's view; the slave modport is the
// control unit plus peripheral side.
interface io_bus_master_if;
  // control-unit handshake
  logic       i_req;
  logic       i_write;
  logic [7:0] i_addr;
  logic [7:0] i_wdata;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rdata;
  // shared data bus and I/O port strobes
  logic [7:0] i_bus;
  logic [7:0] o_bus;
  logic       o_busNOE;
  logic       o_ioSelect;
  logic [7:0] o_ioAddress;
  logic       o_ioNOE;
  logic       o_ioNWE;

  modport master (
    input  i_req, i_write, i_addr, i_wdata, i_bus,
    output o_busy, o_done, o_rdata, o_bus, o_busNOE,
           o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE
  );

  modport slave (
    output i_req, i_write, i_addr, i_wdata, i_bus,
    input  o_busy, o_done, o_rdata, o_bus, o_busNOE,
           o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE
  );
endinterface

// File: rtl/io_bus_master.sv
// Initiator for the CPU I/O port: turns a one-cycle request into a
// select / address / strobe sequence (IDLE -> SETUP -> STROBE -> HOLD).
// Every port output is a flop, so the strobe lines cannot glitch.
module io_bus_master #(
  parameter int STROBE_CYCLES = 2  // cycles the active strobe is held low, 1..15
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  io_bus_master_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_e     state_r;
  logic [3:0] cnt_r;
  logic       write_r;

  // Transaction sequencer; outputs are registered alongside the state so each
  // output value already reflects the state being entered.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r         <= IDLE;
      cnt_r           <= 4'd0;
      write_r         <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_rdata     <= 8'h00;
      bus.o_bus       <= 8'h00;
      bus.o_busNOE    <= 1'b1;
      bus.o_ioSelect  <= 1'b0;
      bus.o_ioAddress <= 8'h00;
      bus.o_ioNOE     <= 1'b1;
      bus.o_ioNWE     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          bus.o_done <= 1'b0;
          if (bus.i_req) begin
            // Latch the whole request; later input changes cannot disturb it.
            state_r         <= SETUP;
            write_r         <= bus.i_write;
            bus.o_busy      <= 1'b1;
            bus.o_ioSelect  <= 1'b1;
            bus.o_ioAddress <= bus.i_addr;
            bus.o_bus       <= bus.i_wdata;
            // Only writes drive the shared bus; reads leave it to the peripheral.
            bus.o_busNOE    <= ~bus.i_write;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          // One cycle of address-to-strobe setup has elapsed; open the strobe.
          state_r     <= STROBE;
          cnt_r       <= STROBE_LOAD;
          bus.o_ioNOE <= write_r;
          bus.o_ioNWE <= ~write_r;
        end
        STROBE: begin
          if (cnt_r == 4'd0) begin
            // Last strobe edge: read data is sampled while NOE is still low.
            state_r     <= HOLD;
            bus.o_ioNOE <= 1'b1;
            bus.o_ioNWE <= 1'b1;
            bus.o_done  <= 1'b1;
            if (!write_r) begin
              bus.o_rdata <= bus.i_bus;
            end else begin
              bus.o_rdata <= bus.o_rdata;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        HOLD: begin
          // Strobes already released; now drop select and the write driver.
          state_r        <= IDLE;
          bus.o_done     <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_ioSelect <= 1'b0;
          bus.o_busNOE   <= 1'b1;
        end
        default: begin
          state_r        <= IDLE;
          bus.o_done     <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_ioSelect <= 1'b0;
          bus.o_busNOE   <= 1'b1;
          bus.o_ioNOE    <= 1'b1;
          bus.o_ioNWE    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: three instances (strobe widths 2, 1, 15),
// a switch peripheral answering reads at 0x00 and a display register
// capturing writes at 0x00.
module tb_io_bus_master;

  logic       clk;
  logic       resetn;
  logic [2:0] req_v;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] switches;
  logic [7:0] disp;
  int         sel;
  int         n_tests;
  int         n_fail;

  io_bus_master_if if2 ();
  io_bus_master_if if1 ();
  io_bus_master_if if15 ();

  io_bus_master #(.STROBE_CYCLES(2))  dut2  (.i_clk(clk), .i_resetn(resetn), .bus(if2.master));
  io_bus_master #(.STROBE_CYCLES(1))  dut1  (.i_clk(clk), .i_resetn(resetn), .bus(if1.master));
  io_bus_master #(.STROBE_CYCLES(15)) dut15 (.i_clk(clk), .i_resetn(resetn), .bus(if15.master));

  assign if2.i_req    = req_v[0];
  assign if1.i_req    = req_v[1];
  assign if15.i_req   = req_v[2];
  assign if2.i_write  = write;
  assign if1.i_write  = write;
  assign if15.i_write = write;
  assign if2.i_addr   = addr;
  assign if1.i_addr   = addr;
  assign if15.i_addr  = addr;
  assign if2.i_wdata  = wdata;
  assign if1.i_wdata  = wdata;
  assign if15.i_wdata = wdata;

  // Switch block at 0x00 drives the bus only while read-strobed; pull-down otherwise.
  assign if2.i_bus  = (if2.o_ioSelect  && if2.o_ioAddress  == 8'h00 && !if2.o_ioNOE)  ? switches : 8'h00;
  assign if1.i_bus  = (if1.o_ioSelect  && if1.o_ioAddress  == 8'h00 && !if1.o_ioNOE)  ? switches : 8'h00;
  assign if15.i_bus = (if15.o_ioSelect && if15.o_ioAddress == 8'h00 && !if15.o_ioNOE) ? switches : 8'h00;

  // Display register at 0x00 on the N=2 master, latching on every write-strobed edge.
  always @(posedge clk) begin
    if (if2.o_ioSelect && if2.o_ioAddress == 8'h00 && !if2.o_ioNWE) disp <= if2.o_bus;
  end

  // Observation mux: selects which instance the checks look at.
  logic       s_sel, s_busy, s_done, s_noe, s_nwe, s_busnoe;
  logic [7:0] s_addr, s_bus, s_rdata;
  always_comb begin
    s_sel = if2.o_ioSelect; s_busy = if2.o_busy; s_done = if2.o_done;
    s_noe = if2.o_ioNOE; s_nwe = if2.o_ioNWE; s_busnoe = if2.o_busNOE;
    s_addr = if2.o_ioAddress; s_bus = if2.o_bus; s_rdata = if2.o_rdata;
    case (sel)
      1: begin
        s_sel = if1.o_ioSelect; s_busy = if1.o_busy; s_done = if1.o_done;
        s_noe = if1.o_ioNOE; s_nwe = if1.o_ioNWE; s_busnoe = if1.o_busNOE;
        s_addr = if1.o_ioAddress; s_bus = if1.o_bus; s_rdata = if1.o_rdata;
      end
      2: begin
        s_sel = if15.o_ioSelect; s_busy = if15.o_busy; s_done = if15.o_done;
        s_noe = if15.o_ioNOE; s_nwe = if15.o_ioNWE; s_busnoe = if15.o_busNOE;
        s_addr = if15.o_ioAddress; s_bus = if15.o_bus; s_rdata = if15.o_rdata;
      end
      default: begin
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, obs, exp);
    end
  endtask

  // Issue one request on instance d (called at a falling edge) and check every
  // output cycle by cycle through cycle n+3. Ends at the falling edge of cycle n+3.
  task automatic run_txn(input int d, input int n, input bit wr, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] rd_exp, input bit keep_req);
    bit act, inb;
    sel = d; write = wr; addr = a; wdata = wd; req_v[d] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_req) begin
        req_v[d] = 1'b0;
        write = ~wr; addr = ~a; wdata = ~wd;
      end
      #1;
      inb = (k <= n + 2);
      act = (k >= 2 && k <= n + 1);
      check_eq("select", s_sel, inb);
      check_eq("busy", s_busy, inb);
      check_eq("done", s_done, k == n + 2);
      check_eq("noe", s_noe, !(!wr && act));
      check_eq("nwe", s_nwe, !(wr && act));
      check_eq("busnoe", s_busnoe, !(wr && inb));
      check_eq("contention", s_busnoe | s_noe, 1'b1);
      if (inb) check_eq("ioaddr", s_addr, a);
      if (wr && inb) check_eq("wbus", s_bus, wd);
      if (!wr && k >= n + 2) check_eq("rdata", s_rdata, rd_exp);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sel = 0;
    resetn = 1'b0; req_v = 3'b111; write = 1'b1; addr = 8'h00; wdata = 8'h00;
    switches = 8'h00; disp = 8'h00;

    // Reset held 3 cycles with requests asserted: everything stays at reset value.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      check_eq("rst_select", s_sel, 1'b0);
      check_eq("rst_ioaddr", s_addr, 8'h00);
      check_eq("rst_noe", s_noe, 1'b1);
      check_eq("rst_nwe", s_nwe, 1'b1);
      check_eq("rst_busnoe", s_busnoe, 1'b1);
      check_eq("rst_bus", s_bus, 8'h00);
      check_eq("rst_busy", s_busy, 1'b0);
      check_eq("rst_done", s_done, 1'b0);
      check_eq("rst_rdata", s_rdata, 8'h00);
    end
    req_v = 3'b000;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    // Write 0xA5 to the display at 0x00.
    run_txn(0, 2, 1'b1, 8'h00, 8'hA5, 8'h00, 1'b0);
    check_eq("disp_a5", disp, 8'hA5);

    // Read the switches; later switch changes must not disturb o_rdata.
    switches = 8'h3C;
    run_txn(0, 2, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0);
    switches = 8'hFF;
    repeat (3) @(negedge clk);
    #1 check_eq("rdata_hold", s_rdata, 8'h3C);

    // Back-to-back writes with i_req held high throughout.
    run_txn(0, 2, 1'b1, 8'h05, 8'h11, 8'h00, 1'b1);
    run_txn(0, 2, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0);
    check_eq("disp_untouched", disp, 8'hA5);

    // Strobe width extremes.
    switches = 8'h5A;
    run_txn(1, 1, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0);
    switches = 8'hC3;
    run_txn(2, 15, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0);

    // Abort a write in STROBE with reset.
    sel = 0; write = 1'b1; addr = 8'h00; wdata = 8'h77; req_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); req_v[0] = 1'b0;
    @(negedge clk); #1;
    check_eq("abort_pre_nwe", s_nwe, 1'b0);
    resetn = 1'b0; #1;
    check_eq("abort_nwe", s_nwe, 1'b1);
    check_eq("abort_noe", s_noe, 1'b1);
    check_eq("abort_busnoe", s_busnoe, 1'b1);
    check_eq("abort_select", s_sel, 1'b0);
    check_eq("abort_busy", s_busy, 1'b0);
    check_eq("abort_rdata", s_rdata, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_eq("abort_done", s_done, 1'b0);
    end
    check_eq("abort_disp", disp, 8'hA5);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); #1;
    check_eq("post_abort_done", s_done, 1'b0);
    @(negedge clk);
    run_txn(0, 2, 1'b1, 8'h00, 8'h3E, 8'h00, 1'b0);
    check_eq("disp_3e", disp, 8'h3E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
